// File: rtl/hdlc_rx_frame_fetch_if.sv
// Register-bus and byte-stream bundle for hdlc_rx_frame_fetch.
// Register side: Address, WriteEnable, ReadEnable, DataIn (to core), DataOut (from core).
// Stream side: m_data, m_valid, m_last, m_ovf (to sink), m_ready (from sink).
interface hdlc_rx_frame_fetch_if;
    logic [2:0] Address;
    logic       WriteEnable;
    logic       ReadEnable;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_ovf;

    modport master (
        output Address,
        output WriteEnable,
        output ReadEnable,
        output DataIn,
        input  DataOut,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last,
        output m_ovf
    );

    modport slave (
        input  Address,
        input  WriteEnable,
        input  ReadEnable,
        input  DataIn,
        output DataOut,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last,
        input  m_ovf
    );
endinterface

// File: rtl/hdlc_rx_frame_fetch.sv
// Drains received frames from the HDLC core Rx buffer: polls Rx_SC, reads Rx_Len,
// fetches Rx_Buff byte by byte and streams it out; errored frames are dropped and counted.
// Ports: Clk, Rst (async active-low), Enable, cfg_fcs_en, bus (register bus + stream),
//        frame_cnt / drop_cnt (wrapping 16-bit frame counters).
module hdlc_rx_frame_fetch #(
    parameter int POLL_GAP = 16,
    parameter int MAX_LEN  = 128
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Enable,
    input  logic                  cfg_fcs_en,
    hdlc_rx_frame_fetch_if.master bus,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int GapW = $clog2(POLL_GAP) + 1;

    localparam logic [2:0] AddrSc  = 3'd2;
    localparam logic [2:0] AddrBuf = 3'd3;
    localparam logic [2:0] AddrLen = 3'd4;

    typedef enum logic [3:0] {
        IDLE,
        GAP,
        POLL_RD,
        POLL_CHK,
        LEN_RD,
        LEN_CHK,
        BUF_RD,
        BUF_CAP,
        OUT,
        DROP
    } fetchState_e;

    fetchState_e    state;
    logic [GapW-1:0] gapCnt;
    logic [7:0]     byteCnt;
    logic [7:0]     frameLen;

    logic [2:0]     addr;
    logic           readEn;
    logic           writeEn;
    logic [7:0]     dataIn;
    logic [7:0]     mData;
    logic           mValid;
    logic           mLast;
    logic           mOvf;
    logic [15:0]    frameCnt;
    logic [15:0]    dropCnt;

    logic           scReady;
    logic           scError;
    logic           lenBad;
    logic [7:0]     dropWord;

    assign scReady  = bus.DataOut[0];
    assign scError  = bus.DataOut[3] | bus.DataOut[2];
    assign lenBad   = (bus.DataOut == 8'd0) || (bus.DataOut > 8'(MAX_LEN));
    // Rx_Drop set, Rx_FCSen carried along so the write does not clobber it.
    assign dropWord = {2'b00, cfg_fcs_en, 3'b000, 1'b1, 1'b0};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            gapCnt   <= '0;
            byteCnt  <= '0;
            frameLen <= '0;
            addr     <= '0;
            readEn   <= 1'b0;
            writeEn  <= 1'b0;
            dataIn   <= '0;
            mData    <= '0;
            mValid   <= 1'b0;
            mLast    <= 1'b0;
            mOvf     <= 1'b0;
            frameCnt <= '0;
            dropCnt  <= '0;
        end else begin
            // Strobes are single-cycle; bus fields idle at zero.
            readEn  <= 1'b0;
            writeEn <= 1'b0;
            addr    <= '0;
            dataIn  <= '0;

            unique case (state)
                IDLE: begin
                    if (Enable) begin
                        state  <= GAP;
                        gapCnt <= '0;
                    end
                end
                GAP: begin
                    if (!Enable) begin
                        state  <= IDLE;
                        gapCnt <= '0;
                    end else if (gapCnt == GapW'(POLL_GAP - 1)) begin
                        state  <= POLL_RD;
                        gapCnt <= '0;
                        readEn <= 1'b1;
                        addr   <= AddrSc;
                    end else begin
                        gapCnt <= gapCnt + GapW'(1);
                    end
                end
                POLL_RD: begin
                    state <= POLL_CHK;
                end
                POLL_CHK: begin
                    if (scError) begin
                        state   <= DROP;
                        writeEn <= 1'b1;
                        addr    <= AddrSc;
                        dataIn  <= dropWord;
                    end else if (scReady) begin
                        state  <= LEN_RD;
                        mOvf   <= bus.DataOut[4];
                        readEn <= 1'b1;
                        addr   <= AddrLen;
                    end else begin
                        state <= GAP;
                    end
                end
                LEN_RD: begin
                    state <= LEN_CHK;
                end
                LEN_CHK: begin
                    frameLen <= bus.DataOut;
                    byteCnt  <= '0;
                    if (lenBad) begin
                        state   <= DROP;
                        writeEn <= 1'b1;
                        addr    <= AddrSc;
                        dataIn  <= dropWord;
                    end else begin
                        state  <= BUF_RD;
                        readEn <= 1'b1;
                        addr   <= AddrBuf;
                    end
                end
                BUF_RD: begin
                    state <= BUF_CAP;
                end
                BUF_CAP: begin
                    state  <= OUT;
                    mData  <= bus.DataOut;
                    mValid <= 1'b1;
                    mLast  <= (byteCnt == frameLen - 8'd1);
                end
                OUT: begin
                    if (bus.m_ready) begin
                        mValid <= 1'b0;
                        mData  <= '0;
                        if (mLast) begin
                            state    <= GAP;
                            mLast    <= 1'b0;
                            mOvf     <= 1'b0;
                            frameCnt <= frameCnt + 16'd1;
                        end else begin
                            state   <= BUF_RD;
                            byteCnt <= byteCnt + 8'd1;
                            readEn  <= 1'b1;
                            addr    <= AddrBuf;
                        end
                    end
                end
                DROP: begin
                    state   <= GAP;
                    mOvf    <= 1'b0;
                    dropCnt <= dropCnt + 16'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Address     = addr;
    assign bus.ReadEnable  = readEn;
    assign bus.WriteEnable = writeEn;
    assign bus.DataIn      = dataIn;
    assign bus.m_data      = mData;
    assign bus.m_valid     = mValid;
    assign bus.m_last      = mLast;
    assign bus.m_ovf       = mOvf;
    assign frame_cnt       = frameCnt;
    assign drop_cnt        = dropCnt;

endmodule
